// File: rtl/gift128_enc_core.sv
// Iterative GIFT-128 encryption core: one round per clock.
// Round keys come from the forward key schedule, which runs alongside the datapath.
module gift128_enc_core #(
  parameter int ROUNDS = 40
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inKeyWr,
  input  logic [127:0] inKeyData,
  input  logic         inDataWr,
  input  logic [127:0] inDataData,
  output logic [127:0] outData,
  output logic         outValid,
  output logic         outBusy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_key;
  logic [127:0] r_wkey;
  logic [127:0] r_state;
  logic [127:0] r_out;
  logic         r_valid;
  logic [5:0]   r_ctr;
  logic [5:0]   r_lfsr;
  logic [5:0]   w_lfsr_nxt;
  logic [127:0] w_round;
  logic [127:0] w_wkey_nxt;
  logic         w_start;
  logic         w_last;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h1;  4'h1: y = 4'ha;  4'h2: y = 4'h4;  4'h3: y = 4'hc;
      4'h4: y = 4'h6;  4'h5: y = 4'hf;  4'h6: y = 4'h3;  4'h7: y = 4'h9;
      4'h8: y = 4'h2;  4'h9: y = 4'hd;  4'ha: y = 4'hb;  4'hb: y = 4'h7;
      4'hc: y = 4'h5;  4'hd: y = 4'h0;  4'he: y = 4'h8;  default: y = 4'he;
    endcase
    return y;
  endfunction

  // Full round: SubCells, PermBits, AddRoundKey, AddConst.
  function automatic logic [127:0] gift_round(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input logic [5:0]   c);
    logic [127:0] sb;
    logic [127:0] pb;
    logic [6:0]   dst;
    sb = '0;
    pb = '0;
    for (int n = 0; n < 32; n++) begin
      sb[4*n +: 4] = sbox(s[4*n +: 4]);
    end
    for (int i = 0; i < 128; i++) begin
      dst = 7'(4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4));
      pb[dst] = sb[i];
    end
    // U = k5||k4 lands on bit 2 of each nibble, V = k1||k0 on bit 1.
    for (int i = 0; i < 32; i++) begin
      pb[4*i+2] = pb[4*i+2] ^ k[64+i];
      pb[4*i+1] = pb[4*i+1] ^ k[i];
    end
    pb[23]  = pb[23] ^ c[5];
    pb[19]  = pb[19] ^ c[4];
    pb[15]  = pb[15] ^ c[3];
    pb[11]  = pb[11] ^ c[2];
    pb[7]   = pb[7]  ^ c[1];
    pb[3]   = pb[3]  ^ c[0];
    pb[127] = ~pb[127];
    return pb;
  endfunction

  // Constant LFSR advances before use, so round 0 sees 6'h01.
  assign w_lfsr_nxt = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4] ^ 1'b1};
  assign w_round    = gift_round(r_state, r_wkey, w_lfsr_nxt);
  assign w_wkey_nxt = {r_wkey[17:16], r_wkey[31:18],
                       r_wkey[11:0],  r_wkey[15:12],
                       r_wkey[127:32]};

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_start   = 1'b0;
    w_last    = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (inDataWr) begin
          w_start   = 1'b1;
          w_fsm_nxt = RUN;
        end
      end
      RUN: begin
        if (r_ctr == 6'(ROUNDS - 1)) begin
          w_last    = 1'b1;
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      r_fsm   <= IDLE;
      r_key   <= '0;
      r_wkey  <= '0;
      r_state <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ctr   <= '0;
      r_lfsr  <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_valid <= w_last;
      if (r_fsm == IDLE) begin
        if (inKeyWr) begin
          r_key <= inKeyData;
        end
        if (w_start) begin
          r_state <= inDataData;
          r_wkey  <= inKeyWr ? inKeyData : r_key;
          r_ctr   <= '0;
          r_lfsr  <= '0;
        end
      end else begin
        r_state <= w_round;
        r_wkey  <= w_wkey_nxt;
        r_lfsr  <= w_lfsr_nxt;
        if (w_last) begin
          r_out <= w_round;
        end else begin
          r_ctr <= r_ctr + 6'd1;
        end
      end
    end
  end

  assign outData  = r_out;
  assign outValid = r_valid;
  assign outBusy  = (r_fsm == RUN);

endmodule
